debug_unit: RTL and testbench
=============================

// Module: debug_unit
// PURPOSE
//  Byte-command controller feeding the pipeline top: loads program bytes into instruction memory,
//  then runs it continuously or single-step. Reports final PC and cycle count.
//  Sits between the UART RX/TX byte interfaces and the pipeline top's control/load inputs.
// PARAMETERS
//  NB_PC         32  width of PC sampled from pipeline
//  NB_MEM_WIDTH  8   byte width of RX/TX and instruction-memory write data
//  NB_IMEM_ADDR  10  instruction-memory byte address width (wraps at 2^NB_IMEM_ADDR)
//  NB_CYCLES     32  cycle counter width
// PORTS
//  i_clock                in   1             system clock, all logic on rising edge
//  i_reset                in   1             synchronous, active-high
//  i_rx_data              in   NB_MEM_WIDTH  received byte
//  i_rx_valid             in   1             1-cycle strobe, i_rx_data valid
//  o_tx_data              out  NB_MEM_WIDTH  report byte
//  o_tx_valid             out  1             report byte valid, held until accepted
//  i_tx_ready             in   1             TX accepts byte when o_tx_valid & i_tx_ready
//  i_pc                   in   NB_PC         current PC from IF stage
//  i_halt                 in   1             HALT instruction retired (level or pulse)
//  o_pc_enable            out  1             to pipeline i_pc_enable
//  o_pc_reset             out  1             to pipeline i_pc_reset
//  o_ID_stage_reset       out  1             to pipeline i_ID_stage_reset
//  o_control_unit_enable  out  1             to pipeline i_control_unit_enable
//  o_write_enable         out  1             instruction-memory byte write strobe
//  o_write_addr           out  NB_IMEM_ADDR  instruction-memory byte address
//  o_write_data           out  NB_MEM_WIDTH  instruction-memory byte data
//  o_busy                 out  1             state != IDLE
// BEHAVIOUR
//  All outputs are registered. Reset values:
//    o_pc_reset=1, o_ID_stage_reset=1.
//    All other outputs 0; internal counters 0; state IDLE.
//  Commands, decoded only in IDLE: 'L'=0x4C load, 'C'=0x43 continuous, 'S'=0x53 step.
//    Other bytes in IDLE are ignored.
//  LOAD: IDLE -L-> LD_LO -byte-> LD_HI -byte-> LD_DATA.
//    The two bytes give word count N (16 bit, LSB first).
//    If N==0, LD_HI returns to IDLE.
//    In LD_DATA each rx byte produces o_write_enable=1 for exactly 1 cycle, the cycle after i_rx_valid.
//    It carries o_write_data=byte at o_write_addr. The address starts at 0 per load and increments after each write.
//    The address wraps modulo 2^NB_IMEM_ADDR.
//    After 4*N bytes, return to IDLE. pc/ID resets stay 1 throughout LOAD.
//  RUN (after 'C'): o_pc_reset=0, o_ID_stage_reset=0, o_control_unit_enable=1, o_pc_enable=1 every cycle.
//    Cycle counter increments each cycle o_pc_enable=1 and saturates at all-ones.
//    On i_halt=1: drop o_pc_enable next cycle, latch i_pc, go REPORT. RX bytes ignored in RUN.
//  STEP (after 'S'): resets deasserted, o_control_unit_enable=1, o_pc_enable=0 by default.
//    'N'=0x4E gives o_pc_enable=1 for exactly one cycle, the cycle after i_rx_valid.
//    'E'=0x45 or i_halt ends STEP: latch i_pc, go REPORT. Other bytes are ignored.
//    If i_halt and 'N' arrive in the same cycle, halt wins and no enable pulse is issued.
//  REPORT: send 8 bytes, LSB first: PC[31:0], then cycle count[31:0].
//    o_tx_valid stays high with o_tx_data stable until i_tx_ready; advance one byte per handshake.
//    After byte 8 is accepted: reassert o_pc_reset/o_ID_stage_reset, clear o_control_unit_enable,
//    clear cycle counter, IDLE.
//    RX ignored in REPORT.
//  i_reset in any state: next cycle all outputs at reset values, partial load/report abandoned.
//  o_pc_enable and o_write_enable are never both 1.
// STRUCTURE
//  Package debug_pkg: command byte localparams (CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_EXIT),
//    state encoding (IDLE, LD_LO, LD_HI, LD_DATA, RUN, STEP, REPORT), REPORT_BYTES=8.
//  Sub-module debug_tx_serializer: loads a 64-bit word and shifts out 8 bytes over valid/ready.
//    It signals done on the final accept.
//  The FSM, load counter and cycle counter live in debug_unit.
// TESTING
//  Reset, then idle 5 cycles -> o_pc_reset=1, o_ID_stage_reset=1, all other outputs 0, o_busy=0.
//  L,0x02,0x00, then 8 bytes 0x10..0x17 -> 8 write pulses, addr 0..7, data 0x10..0x17; then IDLE.
//  L,0x00,0x00 -> no write pulse; IDLE one cycle after the 3rd byte.
//  C, with i_halt raised 20 cycles later and i_pc=0x24 -> cycle count 20.
//    TX bytes 24,00,00,00,14,00,00,00, each held until i_tx_ready.
//  S, N x3, E -> three 1-cycle o_pc_enable pulses; report has count=3.
//    Same-cycle N+i_halt -> no pulse, report issued.
//  i_reset asserted mid-LD_DATA (after 3 of 8 bytes) -> reset values; next load restarts at addr 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants for the debug controller: command bytes, FSM state codes, report length.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_EXIT = 8'h45;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LD_LO   = 3'd1;
    localparam logic [2:0] LD_HI   = 3'd2;
    localparam logic [2:0] LD_DATA = 3'd3;
    localparam logic [2:0] RUN     = 3'd4;
    localparam logic [2:0] STEP    = 3'd5;
    localparam logic [2:0] REPORT  = 3'd6;

    localparam int REPORT_BYTES = 8;

endpackage

// File: rtl/debug_tx_serializer.sv
// Shifts a loaded word out LSB byte first; first byte valid the cycle after i_load.
// Each byte is held until i_tx_ready; o_done pulses on the last accept.
module debug_tx_serializer #(
    parameter int NB_BYTE = 8,
    parameter int N_BYTES = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_load,
    input  logic [NB_BYTE*N_BYTES-1:0] i_word,
    output logic [NB_BYTE-1:0]         o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_done
);
    localparam int NB_WORD = NB_BYTE * N_BYTES;
    localparam int NB_CNT  = $clog2(N_BYTES);

    logic [NB_WORD-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               accept;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        accept  = valid_q & i_tx_ready;
        o_done  = accept && (cnt_q == NB_CNT'(N_BYTES - 1));
        if (i_load) begin
            shift_d = i_word;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            shift_d = shift_q >> NB_BYTE;
            cnt_d   = cnt_q + 1'b1;
            if (o_done) valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_tx_data  = shift_q[NB_BYTE-1:0];
    assign o_tx_valid = valid_q;

endmodule

// File: rtl/debug_unit.sv
// Byte-command debug controller: loads instruction memory, runs/steps the pipeline, reports PC and cycle count.
// All outputs registered (one cycle after the causing rx byte / halt); report bytes held until i_tx_ready.
module debug_unit #(
    parameter int NB_PC        = 32,
    parameter int NB_MEM_WIDTH = 8,
    parameter int NB_IMEM_ADDR = 10,
    parameter int NB_CYCLES    = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic [NB_MEM_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    input  logic [NB_PC-1:0]        i_pc,
    input  logic                    i_halt,
    output logic                    o_pc_enable,
    output logic                    o_pc_reset,
    output logic                    o_ID_stage_reset,
    output logic                    o_control_unit_enable,
    output logic                    o_write_enable,
    output logic [NB_IMEM_ADDR-1:0] o_write_addr,
    output logic [NB_MEM_WIDTH-1:0] o_write_data,
    output logic                    o_busy
);
    import debug_pkg::*;

    localparam int NB_LEFT = 2 * NB_MEM_WIDTH + 2;

    logic [2:0]              state_q, state_d;
    logic [NB_MEM_WIDTH-1:0] lo_q, lo_d;
    logic [NB_LEFT-1:0]      left_q, left_d;
    logic [NB_IMEM_ADDR-1:0] addr_q, addr_d;
    logic [NB_IMEM_ADDR-1:0] write_addr_q, write_addr_d;
    logic [NB_MEM_WIDTH-1:0] write_data_q, write_data_d;
    logic                    write_en_q, write_en_d;
    logic                    pc_enable_q, pc_enable_d;
    logic                    pc_reset_q, pc_reset_d;
    logic                    id_reset_q, id_reset_d;
    logic                    cu_enable_q, cu_enable_d;
    logic                    busy_q, busy_d;
    logic [NB_CYCLES-1:0]    cycles_q, cycles_d;
    logic                    go_report;
    logic                    in_exec;
    logic                    tx_done;
    logic [NB_CYCLES+NB_PC-1:0] report_word;

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        left_d       = left_q;
        addr_d       = addr_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        write_en_d   = 1'b0;
        pc_enable_d  = 1'b0;
        go_report    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d = LD_LO;
                            addr_d  = '0;
                        end
                        CMD_CONT: state_d = RUN;
                        CMD_STEP: state_d = STEP;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            LD_LO: begin
                if (i_rx_valid) begin
                    lo_d    = i_rx_data;
                    state_d = LD_HI;
                end
            end
            LD_HI: begin
                if (i_rx_valid) begin
                    if ({i_rx_data, lo_q} == '0) begin
                        state_d = IDLE;
                    end else begin
                        left_d  = {i_rx_data, lo_q, 2'b00};
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (i_rx_valid) begin
                    write_en_d   = 1'b1;
                    write_addr_d = addr_q;
                    write_data_d = i_rx_data;
                    addr_d       = addr_q + 1'b1;
                    left_d       = left_q - 1'b1;
                    if (left_q == NB_LEFT'(1)) state_d = IDLE;
                end
            end
            RUN: begin
                if (i_halt) begin
                    go_report = 1'b1;
                    state_d   = REPORT;
                end
            end
            STEP: begin
                // halt takes priority over a coincident step request
                if (i_halt || (i_rx_valid && i_rx_data == CMD_EXIT)) begin
                    go_report = 1'b1;
                    state_d   = REPORT;
                end else if (i_rx_valid && i_rx_data == CMD_NEXT) begin
                    pc_enable_d = 1'b1;
                end
            end
            REPORT: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN) pc_enable_d = 1'b1;

        // count includes the enabled cycle that ends on the halt edge, so the report sees it
        cycles_d = cycles_q;
        if (pc_enable_q && cycles_q != '1) cycles_d = cycles_q + 1'b1;
        if (state_q == REPORT && tx_done)  cycles_d = '0;

        in_exec     = (state_d == RUN) || (state_d == STEP) || (state_d == REPORT);
        pc_reset_d  = !in_exec;
        id_reset_d  = !in_exec;
        cu_enable_d = in_exec;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= IDLE;
            lo_q         <= '0;
            left_q       <= '0;
            addr_q       <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            pc_enable_q  <= 1'b0;
            pc_reset_q   <= 1'b1;
            id_reset_q   <= 1'b1;
            cu_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            cycles_q     <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            left_q       <= left_d;
            addr_q       <= addr_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            pc_enable_q  <= pc_enable_d;
            pc_reset_q   <= pc_reset_d;
            id_reset_q   <= id_reset_d;
            cu_enable_q  <= cu_enable_d;
            busy_q       <= busy_d;
            cycles_q     <= cycles_d;
        end
    end

    assign report_word = {cycles_d, i_pc};

    debug_tx_serializer #(
        .NB_BYTE (NB_MEM_WIDTH),
        .N_BYTES (REPORT_BYTES)
    ) u_tx_ser (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (go_report),
        .i_word     (report_word),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (tx_done)
    );

    assign o_pc_enable           = pc_enable_q;
    assign o_pc_reset            = pc_reset_q;
    assign o_ID_stage_reset      = id_reset_q;
    assign o_control_unit_enable = cu_enable_q;
    assign o_write_enable        = write_en_q;
    assign o_write_addr          = write_addr_q;
    assign o_write_data          = write_data_q;
    assign o_busy                = busy_q;

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit against a transaction-level model of load/run/step/report.
module tb_debug_unit;

    localparam logic [7:0] K_L = 8'h4C;
    localparam logic [7:0] K_C = 8'h43;
    localparam logic [7:0] K_S = 8'h53;
    localparam logic [7:0] K_N = 8'h4E;
    localparam logic [7:0] K_E = 8'h45;
    localparam int IMEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] pc;
    logic        halt;
    logic        pc_en, pc_rst, id_rst, cu_en, we, busy;
    logic [9:0]  waddr;
    logic [7:0]  wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;
    int wr_cnt  = 0;
    bit overlap = 1'b0;

    always #5 clk = ~clk;

    debug_unit dut (
        .i_clock               (clk),
        .i_reset               (rst),
        .i_rx_data             (rx_data),
        .i_rx_valid            (rx_valid),
        .o_tx_data             (tx_data),
        .o_tx_valid            (tx_valid),
        .i_tx_ready            (tx_ready),
        .i_pc                  (pc),
        .i_halt                (halt),
        .o_pc_enable           (pc_en),
        .o_pc_reset            (pc_rst),
        .o_ID_stage_reset      (id_rst),
        .o_control_unit_enable (cu_en),
        .o_write_enable        (we),
        .o_write_addr          (waddr),
        .o_write_data          (wdata),
        .o_busy                (busy)
    );

    always @(negedge clk) begin
        if (pc_en) en_cnt = en_cnt + 1;
        if (we)    wr_cnt = wr_cnt + 1;
        if (pc_en && we) overlap = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pc_reset"}, pc_rst, 1);
        chk({tag, "_id_reset"}, id_rst, 1);
        chk({tag, "_pc_en"},    pc_en, 0);
        chk({tag, "_cu_en"},    cu_en, 0);
        chk({tag, "_we"},       we, 0);
        chk({tag, "_waddr"},    waddr, 0);
        chk({tag, "_wdata"},    wdata, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"},  tx_data, 0);
        chk({tag, "_busy"},     busy, 0);
    endtask

    task automatic do_load(input int n_words, input bit fixed_data);
        int          base_wr;
        logic [15:0] n16;
        logic [7:0]  b;
        n16     = 16'(n_words);
        base_wr = wr_cnt;
        send_byte(K_L);
        chk("ld_busy", busy, 1);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        if (n_words == 0) chk("ld0_idle", busy, 0);
        for (int i = 0; i < 4 * n_words; i++) begin
            b = fixed_data ? 8'(8'h10 + i) : 8'($urandom);
            send_byte(b);
            chk("wr_en", we, 1);
            chk("wr_addr", waddr, 64'(i % IMEM_BYTES));
            chk("wr_data", wdata, b);
            if (i == 0) begin
                chk("ld_pc_reset", pc_rst, 1);
                chk("ld_id_reset", id_rst, 1);
                chk("ld_pc_en", pc_en, 0);
            end
        end
        chk("ld_done_idle", busy, 0);
        @(negedge clk);
        chk("ld_wr_count", 64'(wr_cnt - base_wr), 64'(4 * n_words));
    endtask

    task automatic receive_report(input logic [31:0] exp_pc, input int exp_cnt);
        logic [63:0] word;
        logic [7:0]  exp_b;
        int          t;
        word = {32'(exp_cnt), exp_pc};
        for (int i = 0; i < 8; i++) begin
            exp_b = word[8*i +: 8];
            t = 0;
            while (!tx_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("tx_valid", tx_valid, 1);
            if (i == 0) begin
                chk("rep_busy", busy, 1);
                chk("rep_pc_reset", pc_rst, 0);
                chk("rep_cu_en", cu_en, 1);
            end
            repeat ($urandom_range(0, 3)) begin
                chk("tx_hold", tx_data, exp_b);
                rx_valid = 1'($urandom_range(0, 1));
                rx_data  = K_S;
                @(negedge clk);
            end
            chk("tx_byte", tx_data, exp_b);
            rx_valid = 1'b0;
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        chk("rep_end_valid", tx_valid, 0);
        chk("rep_end_busy", busy, 0);
        chk("rep_end_pc_reset", pc_rst, 1);
        chk("rep_end_id_reset", id_rst, 1);
        chk("rep_end_cu_en", cu_en, 0);
    endtask

    task automatic do_run(input int k, input logic [31:0] hpc);
        int base_en;
        base_en = en_cnt;
        send_byte(K_C);
        chk("run_pc_en", pc_en, 1);
        chk("run_pc_reset", pc_rst, 0);
        chk("run_id_reset", id_rst, 0);
        chk("run_cu_en", cu_en, 1);
        chk("run_busy", busy, 1);
        repeat (k - 1) @(negedge clk);
        halt = 1'b1;
        pc   = hpc;
        @(negedge clk);
        halt = 1'b0;
        pc   = $urandom;
        chk("run_halt_pc_en", pc_en, 0);
        receive_report(hpc, k);
        chk("run_en_cycles", 64'(en_cnt - base_en), 64'(k));
    endtask

    // mode 0: 'E' ends, 1: halt alone, 2: halt together with 'N'
    task automatic do_step(input int n_next, input int mode);
        int          base_en;
        logic [31:0] hpc;
        logic [7:0]  junk;
        base_en = en_cnt;
        send_byte(K_S);
        chk("step_pc_en", pc_en, 0);
        chk("step_cu_en", cu_en, 1);
        chk("step_pc_reset", pc_rst, 0);
        chk("step_busy", busy, 1);
        for (int j = 0; j < n_next; j++) begin
            if ($urandom_range(0, 1) == 1) begin
                junk = 8'($urandom);
                if (junk == K_N || junk == K_E) junk = K_C;
                send_byte(junk);
                chk("step_junk_pc_en", pc_en, 0);
            end
            send_byte(K_N);
            chk("step_pulse", pc_en, 1);
            @(negedge clk);
            chk("step_pulse_len", pc_en, 0);
        end
        hpc = $urandom;
        @(negedge clk);
        pc = hpc;
        if (mode == 0) begin
            rx_data  = K_E;
            rx_valid = 1'b1;
        end else begin
            halt = 1'b1;
            if (mode == 2) begin
                rx_data  = K_N;
                rx_valid = 1'b1;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        halt     = 1'b0;
        pc       = $urandom;
        chk("step_end_pc_en", pc_en, 0);
        receive_report(hpc, n_next);
        chk("step_en_cycles", 64'(en_cnt - base_en), 64'(n_next));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] junk;
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        pc       = '0;
        halt     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_held");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_vals("rst_idle");

        do_load(2, 1'b1);
        do_load(0, 1'b0);
        do_run(20, 32'h24);
        do_step(3, 0);
        do_step(2, 2);

        // abandon a load part-way, then reload from address 0
        send_byte(K_L);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid_load");
        rst = 1'b0;
        do_load(2, 1'b0);

        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 3))
                0: do_load($urandom_range(1, 4), 1'b0);
                1: do_run($urandom_range(1, 40), $urandom);
                2: do_step($urandom_range(0, 4), $urandom_range(0, 2));
                default: begin
                    junk = 8'($urandom);
                    if (junk == K_L || junk == K_C || junk == K_S) junk = 8'h00;
                    send_byte(junk);
                    chk("idle_junk_busy", busy, 0);
                end
            endcase
        end

        do_load(257, 1'b0);
        chk("enables_exclusive", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
